// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder sequencer: state type and encodings.
package bsa_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the bit-slice of serial arithmetic blocks.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder: one shared full_adder processes the operands LSB first,
// one bit per clock, behind a start/busy/done handshake.
module bit_serial_add_ctrl
  import bsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fa_s;
  logic             fa_cout;
  logic             unused_res_lsb;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // The new sum bit enters at the MSB so that after WIDTH steps bit 0 is the first one computed.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_nxt = fa_s;
    end else begin : g_res_wn
      assign res_nxt = {fa_s, res_sr[WIDTH-1:1]};
    end
  endgenerate

  assign unused_res_lsb = res_sr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_sr  <= res_nxt;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            sum_q   <= res_nxt;
            cout_q  <= fa_cout;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/bit_serial_add_ctrl.md
Name: bit_serial_add_ctrl

Overview:
Sequencer that time-shares one full_adder cell to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock. It holds operand and result shift registers, a carry flip-flop and a bit counter. A start/busy/done handshake sits in front of it. It is the area-minimal adder for slow control paths and the first consumer of the team's full_adder cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  operand A; captured on accepted start
b      input   WIDTH  operand B; captured on accepted start
cin    input   1      carry-in; captured on accepted start
busy   output  1      high in RUN and DONE; start is ignored while high
done   output  1      single-cycle pulse; result valid
sum    output  WIDTH  registered result; held until the next completion
cout   output  1      registered final carry; held with sum

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of the current state:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, result shift register, carry flip-flop and counter all cleared.
- Reset mid-operation: aborts the add; no done pulse; sum/cout read 0.
- FSM: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge E0: load a_sr=a, b_sr=b, carry=cin, cnt=0; go to RUN.
  - start=0: stay.
- RUN (busy=1), at each edge:
  - The full_adder is fed a_sr[0], b_sr[0], carry.
  - Its s is shifted into the result register MSB: res_sr <= {s, res_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right; carry <= cout; cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge: sum <= {s, res_sr[WIDTH-1:1]}, cout <= full_adder cout; go to DONE.
- DONE:
  - busy=1, done=1 for exactly one cycle; go to IDLE at the next edge.
  - start in DONE is ignored (not queued).
- Latency: start accepted at E0, the WIDTH bit-steps occupy edges E1..EWIDTH, done is high between edges EWIDTH and EWIDTH+1. Sum/cout become valid when done rises and stay stable through subsequent IDLE cycles. Throughput is one add per WIDTH+2 cycles.
- Counter width: clog2(WIDTH+1) bits. Counter is compared, never wrapped.
- Arithmetic: {cout,sum} == a + b + cin modulo 2^(WIDTH+1), using operand values captured at E0. Later changes on a/b/cin have no effect.
- start held high continuously: one add per WIDTH+2 cycles; start is re-sampled only in IDLE.
- WIDTH=1: a single RUN cycle; same timing rules apply.
- Outputs are driven from flops only; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package bsa_pkg:
  - State encoding constants: ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10; 2'b11 is illegal and recovers to IDLE.
  - Typedef for the 2-bit state.
- Sub-module: one instance of the existing full_adder cell (ports a, b, cin, s, cout) as the bit-slice.
- Everything else (FSM, shift registers, counter, result registers) lives in bit_serial_add_ctrl.

Test Plan:
- WIDTH=8, after reset: sum=0x00, cout=0, busy=0, done=0. a=0x3C, b=0x42, cin=0, 1-cycle start -> busy high for 9 cycles; done pulses exactly 9 cycles after the start edge; sum=0x7E, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple). Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- Start pulsed again 3 cycles into RUN, and a/b changed to 0x11 mid-run -> no effect. First result is unchanged; exactly one done pulse; no second add until start is asserted in IDLE.
- start held high for 30 cycles with a=0x80, b=0x80, cin=0 -> done pulses at cycles 9, 19, 29 after the first start edge; each result is sum=0x00, cout=1.
- Drive rst_n low asynchronously (between clock edges) 4 cycles into RUN -> busy, done, sum and cout go to 0 immediately; no done pulse. After release, a=0x01, b=0x01, cin=1 -> sum=0x03, cout=0.
- Random checker over 1000 adds, each with a randomized 0-5 cycle idle gap before the start pulse -> {cout,sum} == a+b+cin; done width is always 1 cycle; busy==0 whenever state is IDLE.
